// File: rtl/inst_req_ctrl_pkg.sv
// inst_req_ctrl_pkg -- shared definitions for the instruction-request path.
//   Pipeline bus widths, in-flight counter width, PC FIFO entry layout and
//   the fetch FSM state encoding used by inst_req_ctrl and inst_ost_fifo.
package inst_req_ctrl_pkg;

  // pipeline bus widths
  localparam int INST_W   = 32;
  localparam int DEF_PC_W = 32;

  // in-flight counters hold 0..4 (largest supported OST_DEPTH)
  localparam int OST_CNT_W = 3;

  // PC FIFO entry = {kill, pc}
  localparam int OST_KILL_W = 1;

  function automatic int ost_entry_w(input int pc_w);
    return pc_w + OST_KILL_W;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_ost_fifo.sv
// inst_ost_fifo -- FIFO of PCs whose address phase finished but whose data
// has not yet returned. Each entry carries a kill flag; flush marks every
// stored entry as killed without removing it, so the matching data_ok can
// still be consumed in order.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push/push_pc/kill   enqueue {kill, pc} (ignored when full and not popping)
//   pop                 dequeue head (ignored when empty)
//   flush               set kill on all stored entries
//   head_pc/head_kill   current head entry
//   count               number of stored entries
module inst_ost_fifo
  import inst_req_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [PC_W-1:0]      push_pc,
  input  logic                 push_kill,
  input  logic                 pop,
  input  logic                 flush,
  output logic [PC_W-1:0]      head_pc,
  output logic                 head_kill,
  output logic [OST_CNT_W-1:0] count
);

  localparam int ENT_W = ost_entry_w(PC_W);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != OST_CNT_W'(DEPTH)) || do_pop);

  assign {head_kill, head_pc} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) mem[i][ENT_W-1] <= 1'b1;
      end
      // pushed entry already carries flush in push_kill
      if (do_push) begin
        mem[wr_ptr] <= {push_kill, push_pc};
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_req_ctrl.sv
// inst_req_ctrl -- instruction fetch request controller between PreIF and an
// SRAM-like instruction port. Holds one request at a time until addr_ok,
// tracks outstanding fetches in a PC FIFO, and buffers returned
// instructions for IF in request order. Flush kills everything in flight.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   fetch_req_i/fetch_pc_i         PreIF fetch request and address
//   fetch_acc_o                    fetch accepted this cycle
//   flush_i                        pipeline flush
//   inst_sram_*                    SRAM-like request/handshake/data
//   if_allowin_i                   IF accepts a response
//   resp_valid_o/pc_o/inst_o       head of response buffer
//   perf_issue_cnt_o, perf_kill_cnt_o  only with INST_REQ_PERF_EN defined
//
// state | meaning
// IDLE  | no request driven; may accept a fetch
// HOLD  | inst_sram_req_o=1, address frozen until addr_ok
module inst_req_ctrl
  import inst_req_ctrl_pkg::*;
#(
  parameter int OST_DEPTH = 2,
  parameter int PC_W      = DEF_PC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req_i,
  input  logic [PC_W-1:0]   fetch_pc_i,
  output logic              fetch_acc_o,
  input  logic              flush_i,
  output logic              inst_sram_req_o,
  output logic [PC_W-1:0]   inst_sram_addr_o,
  input  logic              inst_sram_addr_ok_i,
  input  logic              inst_sram_data_ok_i,
  input  logic [INST_W-1:0] inst_sram_rdata_i,
  input  logic              if_allowin_i,
  output logic              resp_valid_o,
  output logic [PC_W-1:0]   resp_pc_o,
  output logic [INST_W-1:0] resp_inst_o
`ifdef INST_REQ_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt_o,
  output logic [31:0]       perf_kill_cnt_o
`endif
);

  // Two entries cover the default depth; deeper configurations grow the
  // buffer so an admitted fetch can never find it full on return.
  localparam int RB_DEPTH = (OST_DEPTH > 2) ? OST_DEPTH : 2;
  localparam int RB_PTR_W = $clog2(RB_DEPTH);
  localparam int SUM_W    = OST_CNT_W + 1;

  fetch_state_e          state, state_nxt;
  logic [PC_W-1:0]       addr_q;
  logic                  hold_kill;
  logic                  ost_push;
  logic                  ost_pop;
  logic                  head_kill;
  logic [PC_W-1:0]       head_pc;
  logic [OST_CNT_W-1:0]  ost_cnt;
  logic [OST_CNT_W-1:0]  rb_cnt;
  logic [SUM_W-1:0]      inflight;
  logic                  room;
  logic                  discard;
  logic                  rb_push;
  logic                  rb_pop;
  logic [RB_PTR_W-1:0]   rb_wr;
  logic [RB_PTR_W-1:0]   rb_rd;
  logic [PC_W-1:0]       rb_pc   [RB_DEPTH];
  logic [INST_W-1:0]     rb_inst [RB_DEPTH];

  assign inflight = {1'b0, ost_cnt} + {1'b0, rb_cnt};
  assign room     = inflight < SUM_W'(OST_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rst_n gates acceptance so fetch_acc_o stays low while reset is held
  always_comb begin
    state_nxt   = state;
    fetch_acc_o = 1'b0;
    ost_push    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && fetch_req_i && !flush_i && room) begin
          fetch_acc_o = 1'b1;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (inst_sram_addr_ok_i) begin
          ost_push  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      hold_kill <= 1'b0;
    end else if (fetch_acc_o) begin
      addr_q    <= fetch_pc_i;
      hold_kill <= 1'b0;
    end else if (state == HOLD && flush_i) begin
      hold_kill <= 1'b1;
    end
  end

  assign inst_sram_req_o  = (state == HOLD);
  assign inst_sram_addr_o = addr_q;

  assign ost_pop = inst_sram_data_ok_i && (ost_cnt != '0);

  inst_ost_fifo #(
    .DEPTH (OST_DEPTH),
    .PC_W  (PC_W)
  ) u_ost_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ost_push),
    .push_pc   (addr_q),
    .push_kill (hold_kill | flush_i),
    .pop       (ost_pop),
    .flush     (flush_i),
    .head_pc   (head_pc),
    .head_kill (head_kill),
    .count     (ost_cnt)
  );

  // a flush coinciding with data_ok kills the returning entry as well
  assign discard = head_kill || flush_i;
  assign rb_push = ost_pop && !discard;
  assign rb_pop  = resp_valid_o && if_allowin_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_cnt <= '0;
      rb_wr  <= '0;
      rb_rd  <= '0;
      for (int i = 0; i < RB_DEPTH; i++) begin
        rb_pc[i]   <= '0;
        rb_inst[i] <= '0;
      end
    end else if (flush_i) begin
      rb_cnt <= '0;
      rb_wr  <= '0;
      rb_rd  <= '0;
    end else begin
      if (rb_push) begin
        rb_pc[rb_wr]   <= head_pc;
        rb_inst[rb_wr] <= inst_sram_rdata_i;
        rb_wr          <= (rb_wr == RB_PTR_W'(RB_DEPTH - 1)) ? '0 : rb_wr + 1'b1;
      end
      if (rb_pop) begin
        rb_rd <= (rb_rd == RB_PTR_W'(RB_DEPTH - 1)) ? '0 : rb_rd + 1'b1;
      end
      case ({rb_push, rb_pop})
        2'b10:   rb_cnt <= rb_cnt + 1'b1;
        2'b01:   rb_cnt <= rb_cnt - 1'b1;
        default: rb_cnt <= rb_cnt;
      endcase
    end
  end

  assign resp_valid_o = (rb_cnt != '0);
  assign resp_pc_o    = rb_pc[rb_rd];
  assign resp_inst_o  = rb_inst[rb_rd];

`ifdef INST_REQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt_o <= '0;
      perf_kill_cnt_o  <= '0;
    end else begin
      if (ost_push)            perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
      if (ost_pop && discard)  perf_kill_cnt_o  <= perf_kill_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_req_ctrl.sv
// tb_inst_req_ctrl -- directed bench for inst_req_ctrl (default parameters).
// A queue models the outstanding fetches; accepted data returns push the
// expected {pc, inst} into a scoreboard popped at each IF handshake.
module tb_inst_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_acc_o;
  logic        flush_i;
  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_addr_ok_i;
  logic        inst_sram_data_ok_i;
  logic [31:0] inst_sram_rdata_i;
  logic        if_allowin_i;
  logic        resp_valid_o;
  logic [31:0] resp_pc_o;
  logic [31:0] resp_inst_o;
`ifdef INST_REQ_PERF_EN
  logic [31:0] perf_issue_cnt_o;
  logic [31:0] perf_kill_cnt_o;
`endif

  always #5 clk = ~clk;

  inst_req_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_req_i         (fetch_req_i),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_acc_o         (fetch_acc_o),
    .flush_i             (flush_i),
    .inst_sram_req_o     (inst_sram_req_o),
    .inst_sram_addr_o    (inst_sram_addr_o),
    .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
    .inst_sram_data_ok_i (inst_sram_data_ok_i),
    .inst_sram_rdata_i   (inst_sram_rdata_i),
    .if_allowin_i        (if_allowin_i),
    .resp_valid_o        (resp_valid_o),
    .resp_pc_o           (resp_pc_o),
    .resp_inst_o         (resp_inst_o)
`ifdef INST_REQ_PERF_EN
    ,
    .perf_issue_cnt_o    (perf_issue_cnt_o),
    .perf_kill_cnt_o     (perf_kill_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    bit          kill;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] sb[$];
  logic [63:0] sb_head;
  int          checks   = 0;
  int          failures = 0;
  int          acc_cnt  = 0;
  int          acc_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // IF side: every handshake must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid_o === 1'b1 && if_allowin_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL resp_unexpected observed pc=%h inst=%h expected none", resp_pc_o, resp_inst_o);
      end
      if (sb.size() != 0) begin
        sb_head = sb.pop_front();
        chk("resp_order", {resp_pc_o, resp_inst_o}, sb_head);
      end
    end
  end

  always @(negedge clk) if (fetch_acc_o === 1'b1) acc_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_flush();
    foreach (mq[i]) mq[i].kill = 1'b1;
    sb.delete();
  endtask

  task automatic model_ret(input logic [31:0] inst);
    ent_t e;
    if (mq.size() != 0) begin
      e = mq.pop_front();
      if (!e.kill && !flush_i) sb.push_back({e.pc, inst});
    end
  endtask

  // accept a fetch, hold it wait_n cycles (flush pulsed at flush_cyc if >= 0),
  // then addr_ok; optionally return the oldest outstanding data that cycle
  task automatic issue(input logic [31:0] pc, input int wait_n, input int flush_cyc,
                       input bit also_ret, input logic [31:0] rinst);
    fetch_req_i = 1'b1;
    fetch_pc_i  = pc;
    #1;
    chk("fetch_acc", fetch_acc_o, 1'b1);
    step();
    fetch_req_i = (wait_n > 0);
    fetch_pc_i  = pc + 32'd4;
    for (int i = 0; i < wait_n; i++) begin
      flush_i = (i == flush_cyc);
      if (flush_i) model_flush();
      #1;
      chk("hold_req", inst_sram_req_o, 1'b1);
      chk("hold_addr", inst_sram_addr_o, pc);
      chk("hold_no_acc", fetch_acc_o, 1'b0);
      step();
    end
    flush_i             = 1'b0;
    fetch_req_i         = 1'b0;
    inst_sram_addr_ok_i = 1'b1;
    if (also_ret) begin
      inst_sram_data_ok_i = 1'b1;
      inst_sram_rdata_i   = rinst;
      model_ret(rinst);
    end
    #1;
    chk("aok_req", inst_sram_req_o, 1'b1);
    chk("aok_addr", inst_sram_addr_o, pc);
    mq.push_back('{pc: pc, kill: (flush_cyc >= 0)});
    step();
    inst_sram_addr_ok_i = 1'b0;
    inst_sram_data_ok_i = 1'b0;
  endtask

  task automatic ret(input logic [31:0] inst, input bit with_flush);
    inst_sram_data_ok_i = 1'b1;
    inst_sram_rdata_i   = inst;
    flush_i             = with_flush;
    if (with_flush) model_flush();
    model_ret(inst);
    step();
    inst_sram_data_ok_i = 1'b0;
    flush_i             = 1'b0;
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    model_flush();
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_valid", resp_valid_o, 1'b0);
  endtask

  initial begin
    rst_n               = 1'b0;
    fetch_req_i         = 1'b1;
    fetch_pc_i          = 32'h1C00_0000;
    flush_i             = 1'b0;
    inst_sram_addr_ok_i = 1'b0;
    inst_sram_data_ok_i = 1'b0;
    inst_sram_rdata_i   = 32'h0;
    if_allowin_i        = 1'b1;

    // reset state
    repeat (2) step();
    #1;
    chk("rst_acc", fetch_acc_o, 1'b0);
    chk("rst_req", inst_sram_req_o, 1'b0);
    chk("rst_addr", inst_sram_addr_o, 32'h0);
    chk("rst_valid", resp_valid_o, 1'b0);
    chk("rst_pc", resp_pc_o, 32'h0);
    chk("rst_inst", resp_inst_o, 32'h0);
    fetch_req_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // single fetch
    issue(32'h1C00_0000, 0, -1, 1'b0, 32'h0);
    step();
    ret(32'h0280_0000, 1'b0);
    #1;
    chk("single_valid", resp_valid_o, 1'b1);
    chk("single_pc", resp_pc_o, 32'h1C00_0000);
    chk("single_inst", resp_inst_o, 32'h0280_0000);
    step();
    #1;
    chk("single_drain", resp_valid_o, 1'b0);

    // data_ok with nothing outstanding is ignored
    ret(32'hDEAD_BEEF, 1'b0);
    #1;
    chk("stray_dok_valid", resp_valid_o, 1'b0);

    // addr_ok withheld 5 cycles: stable address, one accept pulse
    acc_base = acc_cnt;
    issue(32'h1C00_0004, 5, -1, 1'b0, 32'h0);
    step();
    chk("acc_once", acc_cnt - acc_base, 1);
    ret(32'h0010_0001, 1'b0);
    step();

    // flush empties a buffered response and kills the outstanding one
    if_allowin_i = 1'b0;
    issue(32'h1C00_0100, 0, -1, 1'b0, 32'h0);
    ret(32'hAAAA_0001, 1'b0);
    #1;
    chk("buf_valid", resp_valid_o, 1'b1);
    issue(32'h1C00_0104, 0, -1, 1'b0, 32'h0);
    flush_pulse();
    ret(32'hAAAA_0002, 1'b0);
    #1;
    chk("killed_valid", resp_valid_o, 1'b0);
    if_allowin_i = 1'b1;

    // two outstanding, flush, both returns discarded, then normal fetch
    issue(32'h1C00_0200, 0, -1, 1'b0, 32'h0);
    issue(32'h1C00_0204, 0, -1, 1'b0, 32'h0);
    flush_pulse();
    ret(32'hBBBB_0001, 1'b0);
    ret(32'hBBBB_0002, 1'b0);
    #1;
    chk("two_killed_valid", resp_valid_o, 1'b0);
    issue(32'h1C00_8000, 0, -1, 1'b0, 32'h0);
    ret(32'h0000_8000, 1'b0);
    step();

    // flush together with data_ok discards the returning entry
    issue(32'h1C00_0300, 0, -1, 1'b0, 32'h0);
    ret(32'hCCCC_0003, 1'b1);
    #1;
    chk("flush_dok_valid", resp_valid_o, 1'b0);

    // flush during HOLD: request held to addr_ok, data discarded
    issue(32'h1C00_0400, 3, 1, 1'b0, 32'h0);
    step();
    ret(32'hDDDD_0004, 1'b0);
    #1;
    chk("hold_flush_valid", resp_valid_o, 1'b0);

    // IF stalled: third fetch blocked until a response drains
    if_allowin_i = 1'b0;
    issue(32'h1C00_0500, 0, -1, 1'b0, 32'h0);
    issue(32'h1C00_0504, 0, -1, 1'b0, 32'h0);
    fetch_req_i = 1'b1;
    fetch_pc_i  = 32'h1C00_0508;
    #1;
    chk("block_ost", fetch_acc_o, 1'b0);
    step();
    ret(32'hEEEE_0500, 1'b0);
    #1;
    chk("block_mix", fetch_acc_o, 1'b0);
    ret(32'hEEEE_0504, 1'b0);
    #1;
    chk("block_buf", fetch_acc_o, 1'b0);
    if_allowin_i = 1'b1;
    #1;
    chk("block_buf_full", fetch_acc_o, 1'b0);
    step();
    issue(32'h1C00_0508, 0, -1, 1'b0, 32'h0);
    ret(32'hEEEE_0508, 1'b0);
    step();

    // addr_ok push with simultaneous data_ok pop; back-to-back returns
    issue(32'h1C00_0600, 0, -1, 1'b0, 32'h0);
    issue(32'h1C00_0604, 0, -1, 1'b1, 32'h0000_0600);
    ret(32'h0000_0604, 1'b0);
    issue(32'h1C00_0608, 0, -1, 1'b0, 32'h0);
    ret(32'h0000_0608, 1'b0);
    step();
    step();

    // reset mid-HOLD drops the request at once
    fetch_req_i = 1'b1;
    fetch_pc_i  = 32'h1C00_0700;
    step();
    fetch_req_i = 1'b0;
    #1;
    chk("pre_rst_req", inst_sram_req_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", inst_sram_req_o, 1'b0);
    chk("async_rst_addr", inst_sram_addr_o, 32'h0);
    mq.delete();
    sb.delete();
    step();
    step();
    rst_n = 1'b1;

    // first request issuable right after reset release
    issue(32'h1C00_0800, 0, -1, 1'b0, 32'h0);
    ret(32'h0000_0800, 1'b0);
    issue(32'h1C00_0804, 0, -1, 1'b0, 32'h0);
    ret(32'h0000_0804, 1'b0);
    issue(32'h1C00_0808, 0, -1, 1'b0, 32'h0);
    ret(32'h0000_0808, 1'b0);
    issue(32'h1C00_080C, 2, 0, 1'b0, 32'h0);
    ret(32'h0000_080C, 1'b0);
    step();
    step();
`ifdef INST_REQ_PERF_EN
    chk("perf_issue", perf_issue_cnt_o, 32'd4);
    chk("perf_kill", perf_kill_cnt_o, 32'd1);
`endif
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("final_valid", resp_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
